board_check_sequencer: RTL and testbench
========================================

Name: board_check_sequencer

Overview:
- Sequences a single shared groupChecker instance over all 12 groups of a 4x4 Sudoku board: 4 rows, 4 columns and 4 2x2 boxes.
- Presents one 16-bit group at a time and waits out the checker latency.
- Accumulates the pass/fail result and reports the whole-board verdict plus the index of the first failing group.
- Sits between the board register file / UI logic and the groupChecker datapath.

Parameters:
- CHECK_LATENCY, 1: CLK edges after grp_digits changes before grp_correct is valid (groupChecker registered output = 1).
- EARLY_ABORT, 1: 1 = finish on the first failing group; 0 = always scan all 12 groups.

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- start  in  1  request a board check; sampled only in IDLE
- board  in  64  16 cells × 4-bit digits; cell (r,c) = board[4*(15-(4r+c)) +: 4]; row 0 in MSBs
- grp_digits  out  16  group presented to groupChecker; element 0 in [15:12]
- grp_correct  in  1  groupChecker verdict for grp_digits
- busy  out  1  check in progress
- done  out  1  one-cycle pulse when the verdict is final
- board_valid  out  1  1 = all groups checked passed; held until next start
- fail_index  out  4  first failing group (0-11); 4'hF if none; held until next start

Behaviour:
- Reset (async, RST_N=0): state=IDLE, grp_digits=0, busy=0, done=0, board_valid=0, fail_index=4'hF, idx=0, wait counter=0.
- Group order:
  - idx 0-3 = rows 0-3, elements in column order.
  - idx 4-7 = columns 0-3, elements in row order.
  - idx 8-11 = boxes: box b covers rows 2*(b/2)..+1 and cols 2*(b%2)..+1, elements row-major.
- State IDLE, start=1 at edge E0:
  - latch board into an internal copy (later board changes are ignored)
  - grp_digits <= group 0; busy <= 1; board_valid <= 1; fail_index <= 4'hF
  - cnt <= CHECK_LATENCY; go to WAIT
- State WAIT, each edge:
  - if cnt != 0: cnt--.
  - if cnt == 0: sample grp_correct and go to EVAL handling in the same edge (below). Each group therefore occupies CHECK_LATENCY+1 edges.
- Sampled grp_correct=0:
  - board_valid <= 0
  - fail_index <= idx, only if fail_index == 4'hF (first failure only)
  - if EARLY_ABORT: go to DONE.
- Otherwise, if idx == 11: go to DONE.
- Otherwise: idx++; grp_digits <= next group; cnt <= CHECK_LATENCY; stay in WAIT.
- Entering DONE:
  - done <= 1; busy <= 0
  - the next edge clears done and returns to IDLE.
- Timing:
  - Full valid pass: done is high in the cycle after edge E0 + 12*(CHECK_LATENCY+1).
  - Early abort at group k: done follows edge E0 + (k+1)*(CHECK_LATENCY+1).
- start while busy or in DONE: ignored. Never queued.
- start held high continuously: a new check begins on the IDLE edge after each done pulse.
- grp_digits holds its last value in IDLE/DONE.
- Reset mid-check: immediate return to reset values; no done pulse.
- Digit 0 or any value >4 is not special-cased; groupChecker's verdict is authoritative.

Decomposition:
- Shared package sudoku_pkg:
  - DIGIT_W=4, GRID_N=4, NUM_GROUPS=12, GROUP_W=16, BOARD_W=64
  - group-index type (4 bits), NO_FAIL=4'hF
  - GRP_ROW0=0, GRP_COL0=4, GRP_BOX0=8
  - state enum {IDLE, WAIT, DONE}
- Sub-module board_group_select: purely combinational; board + idx -> 16-bit group. It is reused later by hint and UI logic.

Test Plan:
- Bench uses a behavioural groupChecker model with latency CHECK_LATENCY.
- Valid board 64'h1234_3412_2143_4321, start pulse, CHECK_LATENCY=1:
  - grp_digits sequence 1234, 3412, 2143, 4321, 1324, 2413, 3142, 4231, 1234, 3412, 2143, 4321
  - each value held 2 cycles
  - done after edge 24; board_valid=1; fail_index=F
- Board 64'h1234_3412_2143_4312, EARLY_ABORT=1:
  - column 2 = 3141 fails
  - done after edge 14; board_valid=0; fail_index=6
- Same board with EARLY_ABORT=0:
  - all 12 groups presented
  - done after edge 24; fail_index=6 (first failure kept although later groups also fail)
- start re-asserted at cycles 3-5 mid-check, and board changed mid-check: grp_digits still derived from the latched board; exactly one done pulse.
- RST_N pulled low during group 5: all outputs return to reset values asynchronously; no done. A following start restarts at group 0.
- CHECK_LATENCY=3 with the valid board: each group held 4 cycles; done after edge 48.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared Sudoku types and geometry for the 4x4 board checker datapath.
package sudoku_pkg;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned GRID_N     = 4;
    localparam int unsigned BOX_N      = 2;
    localparam int unsigned NUM_GROUPS = 12;
    localparam int unsigned GROUP_W    = 16;
    localparam int unsigned BOARD_W    = 64;

    typedef logic [3:0] grp_idx_t;

    localparam grp_idx_t NO_FAIL  = 4'hF;
    localparam grp_idx_t GRP_ROW0 = 4'd0;
    localparam grp_idx_t GRP_COL0 = 4'd4;
    localparam grp_idx_t GRP_BOX0 = 4'd8;
    localparam grp_idx_t GRP_LAST = 4'd11;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} seq_state_t;

    // Row 0 sits in the board MSBs, so cell (r,c) counts down from the top.
    function automatic int unsigned cell_lsb(input int unsigned r, input int unsigned c);
        return DIGIT_W * (GRID_N * GRID_N - 1 - (GRID_N * r + c));
    endfunction
endpackage

// File: rtl/board_check_sequencer_if.sv
// Link between the board sequencer and the shared groupChecker datapath.
interface board_check_sequencer_if;
    logic [sudoku_pkg::GROUP_W-1:0] grp_digits;
    logic                           grp_correct;

    modport master (output grp_digits, input grp_correct);
    modport slave  (input grp_digits, output grp_correct);
endinterface

// File: rtl/board_group_select.sv
// Combinational extraction of one row, column or 2x2 box from a 4x4 board.
module board_group_select
    import sudoku_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    input  grp_idx_t           idx,
    output logic [GROUP_W-1:0] group
);

    always_comb begin
        group = '0;
        for (int unsigned e = 0; e < GRID_N; e++) begin
            int unsigned r;
            int unsigned c;
            int unsigned b;
            r = 0;
            c = 0;
            b = 0;
            if (idx < GRP_COL0) begin
                r = 32'(idx);
                c = e;
            end else if (idx < GRP_BOX0) begin
                r = e;
                c = 32'(idx - GRP_COL0);
            end else begin
                b = 32'(idx - GRP_BOX0);
                r = BOX_N * (b / BOX_N) + e / BOX_N;
                c = BOX_N * (b % BOX_N) + e % BOX_N;
            end
            // Indices past the last box yield an all-zero group.
            if (idx <= GRP_LAST)
                group[GROUP_W - DIGIT_W * (e + 1) +: DIGIT_W] = board[cell_lsb(r, c) +: DIGIT_W];
        end
    end

endmodule

// File: rtl/board_check_sequencer.sv
// Walks all 12 groups of a latched 4x4 board through one groupChecker and reports the verdict.
module board_check_sequencer
    import sudoku_pkg::*;
#(
    parameter int unsigned CHECK_LATENCY = 1,
    parameter bit          EARLY_ABORT   = 1'b1
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      start,
    input  logic [BOARD_W-1:0]        board,
    board_check_sequencer_if.master   chk,
    output logic                      busy,
    output logic                      done,
    output logic                      board_valid,
    output grp_idx_t                  fail_index
);

    localparam int unsigned CNT_W = (CHECK_LATENCY > 1) ? $clog2(CHECK_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CHECK_LATENCY);

    seq_state_t         state, state_d;
    logic [BOARD_W-1:0] board_q, board_d;
    logic [GROUP_W-1:0] grp_d;
    logic               busy_d, done_d, valid_d;
    grp_idx_t           fail_d;
    grp_idx_t           idx, idx_d;
    logic [CNT_W-1:0]   cnt, cnt_d;

    logic [BOARD_W-1:0] sel_board;
    grp_idx_t           sel_idx;
    logic [GROUP_W-1:0] sel_group;
    logic               finish;

    // In IDLE the selector looks at the live board so group 0 is ready on the start edge.
    assign sel_board = (state == IDLE) ? board : board_q;
    assign sel_idx   = (state == IDLE) ? GRP_ROW0 : idx + 4'd1;

    board_group_select u_select (
        .board (sel_board),
        .idx   (sel_idx),
        .group (sel_group)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state          <= IDLE;
            board_q        <= '0;
            chk.grp_digits <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            board_valid    <= 1'b0;
            fail_index     <= NO_FAIL;
            idx            <= '0;
            cnt            <= '0;
        end else begin
            state          <= state_d;
            board_q        <= board_d;
            chk.grp_digits <= grp_d;
            busy           <= busy_d;
            done           <= done_d;
            board_valid    <= valid_d;
            fail_index     <= fail_d;
            idx            <= idx_d;
            cnt            <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        board_d = board_q;
        grp_d   = chk.grp_digits;
        busy_d  = busy;
        done_d  = done;
        valid_d = board_valid;
        fail_d  = fail_index;
        idx_d   = idx;
        cnt_d   = cnt;
        finish  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    board_d = board;
                    grp_d   = sel_group;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    fail_d  = NO_FAIL;
                    idx_d   = GRP_ROW0;
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                end else begin
                    if (!chk.grp_correct) begin
                        valid_d = 1'b0;
                        if (fail_index == NO_FAIL)
                            fail_d = idx;
                    end
                    finish = (!chk.grp_correct && EARLY_ABORT) || (idx == GRP_LAST);
                    if (finish) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx + 4'd1;
                        grp_d = sel_group;
                        cnt_d = CNT_LOAD;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_board_check_sequencer.sv
// Directed checks of board_check_sequencer against a behavioural groupChecker.
module tb_board_check_sequencer;

    localparam logic [63:0] VALID_B = 64'h1234_3412_2143_4321;
    localparam logic [63:0] BAD_B   = 64'h1234_3412_2143_4312;
    localparam logic [63:0] ROW0_B  = 64'h1134_3412_2143_4321;
    localparam logic [63:0] LATIN_B = 64'h1234_2341_3412_4123;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start [3];
    logic [63:0] brd   [3];
    logic        busy  [3];
    logic        done  [3];
    logic        vld   [3];
    logic [3:0]  fidx  [3];
    logic [15:0] dig   [3];
    logic [2:0]  pipe2 = '0;

    int checks = 0;
    int errors = 0;

    logic [0:11][15:0] vseq;
    logic [0:11][15:0] bseq;

    always #5 clk = ~clk;

    board_check_sequencer_if chk0 ();
    board_check_sequencer_if chk1 ();
    board_check_sequencer_if chk2 ();

    board_check_sequencer #(.CHECK_LATENCY(1), .EARLY_ABORT(1'b1)) dut0 (
        .CLK(clk), .RST_N(rst_n), .start(start[0]), .board(brd[0]), .chk(chk0),
        .busy(busy[0]), .done(done[0]), .board_valid(vld[0]), .fail_index(fidx[0]));
    board_check_sequencer #(.CHECK_LATENCY(1), .EARLY_ABORT(1'b0)) dut1 (
        .CLK(clk), .RST_N(rst_n), .start(start[1]), .board(brd[1]), .chk(chk1),
        .busy(busy[1]), .done(done[1]), .board_valid(vld[1]), .fail_index(fidx[1]));
    board_check_sequencer #(.CHECK_LATENCY(3), .EARLY_ABORT(1'b1)) dut2 (
        .CLK(clk), .RST_N(rst_n), .start(start[2]), .board(brd[2]), .chk(chk2),
        .busy(busy[2]), .done(done[2]), .board_valid(vld[2]), .fail_index(fidx[2]));

    assign dig[0] = chk0.grp_digits;
    assign dig[1] = chk1.grp_digits;
    assign dig[2] = chk2.grp_digits;

    function automatic logic is_perm(input logic [15:0] g);
        logic [4:0] seen;
        logic [3:0] d;
        seen = '0;
        for (int i = 0; i < 4; i++) begin
            d = g[4*i +: 4];
            if (d >= 4'd1 && d <= 4'd4) seen[d] = 1'b1;
        end
        return seen[4:1] == 4'hF;
    endfunction

    always @(posedge clk) begin
        chk0.grp_correct <= is_perm(chk0.grp_digits);
        chk1.grp_correct <= is_perm(chk1.grp_digits);
        pipe2            <= {pipe2[1:0], is_perm(chk2.grp_digits)};
    end
    assign chk2.grp_correct = pipe2[2];

    typedef struct {
        int                sel;
        int                lat;
        logic [63:0]       board;
        int                n_seq;
        logic [0:11][15:0] seq;
        int                exp_edge;
        logic              exp_valid;
        logic [3:0]        exp_fail;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        int   n;
        int   bad;
        v = vecs[k];
        brd[v.sel]   = v.board;
        start[v.sel] = 1'b1;
        tick();
        start[v.sel] = 1'b0;
        chk_eq($sformatf("v%0d_busy_start", k), 64'(busy[v.sel]), 64'd1);
        n   = 0;
        bad = 0;
        while (done[v.sel] !== 1'b1 && n < 200) begin
            if (n < v.n_seq * (v.lat + 1) && dig[v.sel] !== v.seq[n / (v.lat + 1)]) bad++;
            tick();
            n++;
        end
        chk_eq($sformatf("v%0d_done_edge", k), 64'(n), 64'(v.exp_edge));
        chk_eq($sformatf("v%0d_valid", k), 64'(vld[v.sel]), 64'(v.exp_valid));
        chk_eq($sformatf("v%0d_fail_index", k), 64'(fidx[v.sel]), 64'(v.exp_fail));
        chk_eq($sformatf("v%0d_busy_done", k), 64'(busy[v.sel]), 64'd0);
        if (v.n_seq > 0) chk_eq($sformatf("v%0d_grp_seq_errs", k), 64'(bad), 64'd0);
        tick();
        chk_eq($sformatf("v%0d_done_pulse", k), 64'(done[v.sel]), 64'd0);
        chk_eq($sformatf("v%0d_valid_held", k), 64'(vld[v.sel]), 64'(v.exp_valid));
    endtask

    initial begin
        int pulses;
        int first_at;
        int second_at;
        int bad;

        vseq = {16'h1234, 16'h3412, 16'h2143, 16'h4321, 16'h1324, 16'h2413,
                16'h3142, 16'h4231, 16'h1234, 16'h3412, 16'h2143, 16'h4321};
        bseq = {16'h1234, 16'h3412, 16'h2143, 16'h4312, 16'h1324, 16'h2413,
                16'h3141, 16'h4232, 16'h1234, 16'h3412, 16'h2143, 16'h4312};

        vecs[0] = '{0, 1, VALID_B, 12, vseq, 24, 1'b1, 4'hF};
        vecs[1] = '{0, 1, BAD_B,    7, bseq, 14, 1'b0, 4'd6};
        vecs[2] = '{1, 1, BAD_B,   12, bseq, 24, 1'b0, 4'd6};
        vecs[3] = '{2, 3, VALID_B, 12, vseq, 48, 1'b1, 4'hF};
        vecs[4] = '{0, 1, ROW0_B,   0, vseq,  2, 1'b0, 4'd0};
        vecs[5] = '{1, 1, LATIN_B,  0, vseq, 24, 1'b0, 4'd8};
        vecs[6] = '{0, 1, LATIN_B,  0, vseq, 18, 1'b0, 4'd8};
        vecs[7] = '{2, 3, ROW0_B,   0, vseq,  4, 1'b0, 4'd0};

        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            start[s] = 1'b0;
            brd[s]   = '0;
        end
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            chk_eq($sformatf("rst%0d_busy", s), 64'(busy[s]), 64'd0);
            chk_eq($sformatf("rst%0d_done", s), 64'(done[s]), 64'd0);
            chk_eq($sformatf("rst%0d_valid", s), 64'(vld[s]), 64'd0);
            chk_eq($sformatf("rst%0d_fail_index", s), 64'(fidx[s]), 64'hF);
            chk_eq($sformatf("rst%0d_grp_digits", s), 64'(dig[s]), 64'd0);
        end
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 8; k++) run_vec(k);

        // Restart requests and a board change while busy must not disturb the scan.
        brd[0]   = VALID_B;
        start[0] = 1'b1;
        tick();
        pulses   = 0;
        first_at = -1;
        bad      = 0;
        for (int n = 1; n <= 40; n++) begin
            start[0] = (n >= 3 && n <= 5);
            if (n == 4) brd[0] = BAD_B;
            if (n - 1 < 24 && dig[0] !== vseq[(n - 1) / 2]) bad++;
            tick();
            if (done[0] === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = n;
            end
        end
        start[0] = 1'b0;
        chk_eq("midstart_pulses", 64'(pulses), 64'd1);
        chk_eq("midstart_done_edge", 64'(first_at), 64'd24);
        chk_eq("midstart_valid", 64'(vld[0]), 64'd1);
        chk_eq("midstart_fail_index", 64'(fidx[0]), 64'hF);
        chk_eq("midstart_grp_seq_errs", 64'(bad), 64'd0);

        // Asynchronous reset while group 5 is on the bus.
        brd[0]   = VALID_B;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (10) tick();
        chk_eq("rstmid_group5", 64'(dig[0]), 64'h2413);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("rstmid_busy", 64'(busy[0]), 64'd0);
        chk_eq("rstmid_done", 64'(done[0]), 64'd0);
        chk_eq("rstmid_valid", 64'(vld[0]), 64'd0);
        chk_eq("rstmid_fail_index", 64'(fidx[0]), 64'hF);
        chk_eq("rstmid_grp_digits", 64'(dig[0]), 64'd0);
        #3;
        rst_n  = 1'b1;
        pulses = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (done[0] === 1'b1) pulses++;
        end
        chk_eq("rstmid_no_done", 64'(pulses), 64'd0);
        run_vec(0);

        // Continuous start: next check begins on the IDLE edge after each done pulse.
        brd[0]    = VALID_B;
        start[0]  = 1'b1;
        tick();
        first_at  = -1;
        second_at = -1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (done[0] === 1'b1) begin
                if (first_at < 0) first_at = n;
                else if (second_at < 0) second_at = n;
            end
        end
        start[0] = 1'b0;
        chk_eq("held_first_done", 64'(first_at), 64'd24);
        chk_eq("held_second_done", 64'(second_at), 64'd50);
        chk_eq("held_busy_third", 64'(busy[0]), 64'd1);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
